channel_in_group_acc: RTL

Consumer end of the 32-input channel-in adder tree. Accumulates the tree's per-pixel SIMD partial sums across successive channel-in groups, holding them in an on-chip partial-sum buffer. Emits each final per-pixel sum once the last group for that pixel has arrived, and pulses done at the end of the pass. Sits between the channel-in reduction tree and the downstream quantisation/activation stage.

---
 rtl/channel_in_group_acc_pkg.sv | 21 ++
 rtl/channel_in_group_acc_if.sv | 36 +++
 rtl/channel_in_group_acc_psum_buffer.sv | 33 +++
 rtl/channel_in_group_acc.sv | 131 +++++++++++++
 4 files changed

// File: rtl/channel_in_group_acc_pkg.sv
// +------------------------------------------------------------------+
// | channel_in_group_acc_pkg : lane geometry and FSM encoding         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package channel_in_group_acc_pkg;

  localparam int PICTURE_NUM    = 4;
  localparam int WIDTH_DATA_OUT = 8;
  localparam int LANE_W         = 2 * WIDTH_DATA_OUT;
  localparam int DATA_W         = PICTURE_NUM * LANE_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/channel_in_group_acc_if.sv
// +------------------------------------------------------------------+
// | channel_in_group_acc_if : control, beat and result signals        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface channel_in_group_acc_if #(
  parameter int ADDR_W = 8,
  parameter int GRP_W  = 8
);
  import channel_in_group_acc_pkg::*;

  logic                i_start;
  logic [ADDR_W:0]     i_pixel_num;
  logic [GRP_W-1:0]    i_group_num;
  logic                i_valid_in;
  logic [DATA_W-1:0]   i_data_in;
  logic [DATA_W-1:0]   o_data_out;
  logic                o_valid_out;
  logic                o_busy;
  logic                o_done;
  logic                o_err;

  modport slave (
    input  i_start, i_pixel_num, i_group_num, i_valid_in, i_data_in,
    output o_data_out, o_valid_out, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_pixel_num, i_group_num, i_valid_in, i_data_in,
    input  o_data_out, o_valid_out, o_busy, o_done, o_err
  );

endinterface

`default_nettype wire

// File: rtl/channel_in_group_acc_psum_buffer.sv
// +------------------------------------------------------------------+
// | channel_in_group_acc_psum_buffer : async-read/sync-write psums    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module channel_in_group_acc_psum_buffer
  import channel_in_group_acc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Not reset: group 0 of every pass overwrites the entries it uses.
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/channel_in_group_acc.sv
// +------------------------------------------------------------------+
// | channel_in_group_acc : accumulates channel-in group partial sums  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module channel_in_group_acc
  import channel_in_group_acc_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int GRP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  channel_in_group_acc_if.slave bus
);

  state_t              r_state;
  logic [ADDR_W:0]     r_pix_num;
  logic [GRP_W-1:0]    r_grp_num;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [GRP_W-1:0]    r_grp_cnt;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_valid_out;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_sum;
  logic                w_beat;
  logic                w_pix_last;
  logic                w_grp_last;
  logic                w_grp_first;
  logic                w_cfg_ok;

  assign w_beat      = (r_state == ST_ACC) && bus.i_valid_in;
  assign w_pix_last  = ({1'b0, r_pix_cnt} == (r_pix_num - (ADDR_W+1)'(1)));
  assign w_grp_last  = (r_grp_cnt == (r_grp_num - GRP_W'(1)));
  assign w_grp_first = (r_grp_cnt == '0);
  assign w_cfg_ok    = (bus.i_pixel_num != '0) &&
                       (bus.i_pixel_num <= (ADDR_W+1)'(DEPTH)) &&
                       (bus.i_group_num != '0);

  channel_in_group_acc_psum_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_psum_buffer (
    .clk     (clk),
    .i_we    (w_beat),
    .i_addr  (r_pix_cnt),
    .i_wdata (w_sum),
    .o_rdata (w_rd_data)
  );

  // Group 0 adds to zero instead of stale buffer contents.
  for (genvar gi = 0; gi < PICTURE_NUM; gi++) begin : g_lane
    logic [LANE_W-1:0] w_base;
    assign w_base = w_grp_first ? '0 : w_rd_data[gi*LANE_W +: LANE_W];
    assign w_sum[gi*LANE_W +: LANE_W] = w_base + bus.i_data_in[gi*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_num   <= '0;
      r_grp_num   <= '0;
      r_pix_cnt   <= '0;
      r_grp_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (w_cfg_ok) begin
              r_pix_num <= bus.i_pixel_num;
              r_grp_num <= bus.i_group_num;
              r_pix_cnt <= '0;
              r_grp_cnt <= '0;
              r_err     <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= ST_ACC;
            end else begin
              r_err <= 1'b1;
            end
          end
          // A beat with no pass running is lost, even alongside a start.
          if (bus.i_valid_in) begin
            r_err <= 1'b1;
          end
        end
        ST_ACC: begin
          if (bus.i_valid_in) begin
            if (w_grp_last) begin
              r_data_out  <= w_sum;
              r_valid_out <= 1'b1;
            end
            if (w_pix_last) begin
              r_pix_cnt <= '0;
              r_grp_cnt <= r_grp_cnt + GRP_W'(1);
              if (w_grp_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_data_out  = r_data_out;
  assign bus.o_valid_out = r_valid_out;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;

endmodule

`default_nettype wire
